// File: rtl/hub75_bcm_scheduler.sv
// rtl/hub75_bcm_scheduler.sv - HUB75 binary-coded-modulation scan scheduler (optional HUB75_BRIGHTNESS_EN)
module hub75_bcm_scheduler #(
    parameter int COLS      = 32,
    parameter int ROWPAIRS  = 32,
    parameter int ADDRBITS  = 5,
    parameter int PLANES    = 8,
    parameter int BASE_ON   = 4,
    parameter int TIMERBITS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [3:0]                brightness,
`endif
    output logic [$clog2(COLS)-1:0]   fb_col,
    output logic [ADDRBITS-1:0]       fb_row,
    output logic [$clog2(PLANES)-1:0] fb_plane,
    input  logic [2:0]                fb_rgb1,
    input  logic [2:0]                fb_rgb2,
    output logic [ADDRBITS-1:0]       led_addr,
    output logic [2:0]                led_rgb1,
    output logic [2:0]                led_rgb2,
    output logic                      led_sclk,
    output logic                      led_latch,
    output logic                      led_blank,
    output logic                      frame_done,
    output logic                      busy
);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PLANES);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WAIT, S_BLANK, S_LATCH, S_UNBLANK} state_t;

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic [CW-1:0]          col_q, col_d;
    logic [ADDRBITS-1:0]    row_q, row_d;
    logic [PW-1:0]          plane_q, plane_d;
    logic [TIMERBITS-1:0]   cnt_q, cnt_d;
    logic [TIMERBITS-1:0]   on_time;
    logic [ADDRBITS-1:0]    addr_q, addr_d;
    logic [2:0]             rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic                   sclk_q, sclk_d;
    logic                   latch_q, latch_d;
    logic                   blank_q, blank_d;
    logic                   done_q, done_d;
    logic                   blank_force;

`ifdef HUB75_BRIGHTNESS_EN
    logic [TIMERBITS+3:0]   scaled;

    // Weighted on-time scaled by (brightness+1)/16 at widened precision
    always_comb begin
        scaled  = (TIMERBITS+4)'(TIMERBITS'(BASE_ON) << plane_q)
                * (TIMERBITS+4)'({1'b0, brightness} + 5'd1);
        on_time = scaled[TIMERBITS+3:4];
    end
`else
    // Weighted on-time of the plane being latched
    always_comb begin
        on_time = TIMERBITS'(BASE_ON) << plane_q;
    end
`endif

    // Next-state, address walk, counter and pin values (pins are registered)
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        col_d       = col_q;
        row_d       = row_q;
        plane_d     = plane_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - TIMERBITS'(1) : cnt_q;
        addr_d      = addr_q;
        rgb1_d      = rgb1_q;
        rgb2_d      = rgb2_q;
        sclk_d      = 1'b0;
        latch_d     = 1'b0;
        done_d      = 1'b0;
        blank_force = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    row_d   = '0;
                    plane_d = '0;
                    col_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!phase_q) begin
                    rgb1_d  = fb_rgb1;
                    rgb2_d  = fb_rgb2;
                    phase_d = 1'b1;
                end else begin
                    sclk_d  = 1'b1;
                    phase_d = 1'b0;
                    if (col_q == CW'(COLS-1)) begin
                        state_d = S_WAIT;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                blank_force = 1'b1;
                state_d     = S_LATCH;
            end
            S_LATCH: begin
                blank_force = 1'b1;
                latch_d     = 1'b1;
                addr_d      = row_q;
                state_d     = S_UNBLANK;
            end
            S_UNBLANK: begin
                cnt_d   = on_time;
                col_d   = '0;
                phase_d = 1'b0;
                if (plane_q == PW'(PLANES-1)) begin
                    plane_d = '0;
                    if (row_q == ADDRBITS'(ROWPAIRS-1)) begin
                        row_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        row_d = row_q + ADDRBITS'(1);
                    end
                end else begin
                    plane_d = plane_q + PW'(1);
                end
                state_d = enable ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Panel stays lit exactly while the on-time counter is nonzero
        blank_d = blank_force | (cnt_d == '0);
    end

    // State and pin registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            plane_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rgb1_q  <= '0;
            rgb2_q  <= '0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
            blank_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            col_q   <= col_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rgb1_q  <= rgb1_d;
            rgb2_q  <= rgb2_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
            blank_q <= blank_d;
            done_q  <= done_d;
        end
    end

    // Framebuffer address leads by one cycle so read data lands in shift phase 0
    assign fb_col     = col_d;
    assign fb_row     = row_d;
    assign fb_plane   = plane_d;
    assign led_addr   = addr_q;
    assign led_rgb1   = rgb1_q;
    assign led_rgb2   = rgb2_q;
    assign led_sclk   = sclk_q;
    assign led_latch  = latch_q;
    assign led_blank  = blank_q;
    assign frame_done = done_q;
    assign busy       = (state_q != S_IDLE) || (cnt_q != '0);
endmodule
